line_buffer_3row: RTL

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

---
 rtl/line_buffer_3row.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/line_buffer_3row.sv
// rtl/line_buffer_3row.sv - three-row luma line buffer producing a vertical 3-tap column
//
// Purpose:
//   Keeps the two previous video lines in local line memories so that every
//   incoming pixel leaves one cycle later together with the pixels directly
//   above it.
//   Top-border rows are zero-filled by default. When LINE_BUFFER_REPLICATE_EN
//   is defined, the top-border rows replicate the nearest real row instead.
//
// Ports:
//   i_pclk         pixel clock, all state changes on its rising edge
//   i_arst         asynchronous active-high reset
//   i_vs           one-cycle start-of-frame pulse
//   i_de           pixel valid, high across the active part of a line
//   i_pixel        raster-order luma pixel
//   o_de           output column valid (i_de delayed by one cycle)
//   o_pixel_11_11  row n-2 tap (top)
//   o_pixel_00_11  row n-1 tap (centre)
//   o_pixel_01_11  row n tap (bottom, the incoming pixel)
//   o_ovf          sticky flag: a line carried more than H_ACTIVE pixels
module line_buffer_3row #(
  parameter int Y_DEPTH  = 8,
  parameter int H_ACTIVE = 640
) (
  input  logic               i_pclk,
  input  logic               i_arst,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [Y_DEPTH-1:0] i_pixel,
  output logic               o_de,
  output logic [Y_DEPTH-1:0] o_pixel_11_11,
  output logic [Y_DEPTH-1:0] o_pixel_00_11,
  output logic [Y_DEPTH-1:0] o_pixel_01_11,
  output logic               o_ovf
);

  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE);

  // line_a holds row n-1 and line_b holds row n-2. Neither memory is
  // cleared, so stale contents are hidden only by the border masking.
  logic [Y_DEPTH-1:0] line_a [H_ACTIVE];
  logic [Y_DEPTH-1:0] line_b [H_ACTIVE];

  logic [CW-1:0]      col;
  logic [1:0]         row;
  logic               de_q;

  logic [CW-1:0]      col_eff;
  logic [1:0]         row_eff;
  logic [AW-1:0]      addr;
  logic               in_range;
  logic               wr_en;
  logic               ovf_beat;
  logic               eol;
  logic [Y_DEPTH-1:0] la_rd;
  logic [Y_DEPTH-1:0] lb_rd;
  logic [Y_DEPTH-1:0] top_nxt;
  logic [Y_DEPTH-1:0] mid_nxt;

  // A start-of-frame pulse restarts the counters before the beat is used,
  // so a beat that coincides with i_vs becomes column 0 of row 0.
  assign col_eff  = i_vs ? '0 : col;
  assign row_eff  = i_vs ? 2'd0 : row;
  assign in_range = (col_eff < COL_MAX);
  assign addr     = col_eff[AW-1:0];
  assign wr_en    = i_de & in_range;
  assign ovf_beat = i_de & ~in_range;
  // End of line is the falling edge of i_de. A falling edge that coincides
  // with i_vs belongs to the aborted line and is not counted.
  assign eol      = de_q & ~i_de & ~i_vs;

  assign la_rd = line_a[addr];
  assign lb_rd = line_b[addr];

  always_comb begin
    top_nxt = '0;
    mid_nxt = '0;
    if (in_range) begin
`ifdef LINE_BUFFER_REPLICATE_EN
      case (row_eff)
        2'd0: begin
          top_nxt = i_pixel;
          mid_nxt = i_pixel;
        end
        2'd1: begin
          top_nxt = la_rd;
          mid_nxt = la_rd;
        end
        default: begin
          top_nxt = lb_rd;
          mid_nxt = la_rd;
        end
      endcase
`else
      case (row_eff)
        2'd0:    ;
        2'd1:    mid_nxt = la_rd;
        default: begin
          top_nxt = lb_rd;
          mid_nxt = la_rd;
        end
      endcase
`endif
    end
  end

  // The line memories have no reset, so they can map onto plain RAM.
  always_ff @(posedge i_pclk) begin
    if (wr_en) begin
      line_b[addr] <= la_rd;
      line_a[addr] <= i_pixel;
    end
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      col  <= '0;
      row  <= 2'd0;
      de_q <= 1'b0;
    end else begin
      de_q <= i_de;
      if (wr_en) begin
        col <= col_eff + CW'(1);
      end else if (eol) begin
        col <= '0;
      end else begin
        col <= col_eff;
      end
      if (eol && (row != 2'd2)) begin
        row <= row + 2'd1;
      end else begin
        row <= row_eff;
      end
    end
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      o_de          <= 1'b0;
      o_ovf         <= 1'b0;
      o_pixel_11_11 <= '0;
      o_pixel_00_11 <= '0;
      o_pixel_01_11 <= '0;
    end else begin
      o_de  <= i_de;
      o_ovf <= (o_ovf & ~i_vs) | ovf_beat;
      if (i_de) begin
        o_pixel_11_11 <= top_nxt;
        o_pixel_00_11 <= mid_nxt;
        o_pixel_01_11 <= i_pixel;
      end
    end
  end

endmodule
